// File: rtl/ht_code_serializer_pkg.sv
// Shared types and width helpers for the Huffman-style code serializer.
package ht_code_serializer_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StShift, StDone} state_e;

  function automatic int unsigned sym_width(input int unsigned nsym);
    return (nsym < 2) ? 1 : $clog2(nsym);
  endfunction

  function automatic int unsigned len_width(input int unsigned maxlen);
    return $clog2(maxlen + 1);
  endfunction

endpackage

// File: rtl/ht_code_table.sv
// Symbol table: NSYM entries of {code, len}, one write port and one async read port.
module ht_code_table
  import ht_code_serializer_pkg::*;
#(
  parameter int unsigned NSYM   = 8,
  parameter int unsigned MAXLEN = 7,
  localparam int unsigned SW    = sym_width(NSYM),
  localparam int unsigned LW    = len_width(MAXLEN)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [SW-1:0]     wr_sym_i,
  input  logic [MAXLEN-1:0] wr_code_i,
  input  logic [LW-1:0]     wr_len_i,
  input  logic [SW-1:0]     rd_sym_i,
  output logic [MAXLEN-1:0] rd_code_o,
  output logic [LW-1:0]     rd_len_o
);

  logic [MAXLEN+LW-1:0] mem_q [NSYM];

  // Only the length field is cleared: a zero length already marks the entry absent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NSYM); i++) begin
        mem_q[i][LW-1:0] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_sym_i] <= {wr_code_i, wr_len_i};
    end
  end

  assign rd_code_o = mem_q[rd_sym_i][MAXLEN+LW-1:LW];
  assign rd_len_o  = mem_q[rd_sym_i][LW-1:0];

endmodule

// File: rtl/ht_code_serializer.sv
// Serializes the code table MSB-first in ascending or descending index order.
module ht_code_serializer
  import ht_code_serializer_pkg::*;
#(
  parameter int unsigned NSYM   = 8,
  parameter int unsigned MAXLEN = 7,
  localparam int unsigned SW    = sym_width(NSYM),
  localparam int unsigned LW    = len_width(MAXLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [SW-1:0]     load_sym,
  input  logic [MAXLEN-1:0] load_code,
  input  logic [LW-1:0]     load_len,
  input  logic              start,
  input  logic              out_mode,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_code,
  output logic              done
);

  state_e            state_q, state_d;
  logic [SW-1:0]     ptr_q, ptr_d, ptr_next;
  logic              mode_q, mode_d;
  logic [MAXLEN-1:0] shreg_q, shreg_d, aligned;
  logic [LW-1:0]     bitcnt_q, bitcnt_d;
  logic              done_q, done_d;
  logic [MAXLEN-1:0] rd_code;
  logic [LW-1:0]     rd_len, wr_len;
  logic              wr_en, ptr_last;

  assign load_ready = (state_q == StIdle);
  assign wr_en      = load_valid && load_ready && (32'(load_sym) < NSYM);
  assign wr_len     = (32'(load_len) > MAXLEN) ? LW'(MAXLEN) : load_len;

  ht_code_table #(
    .NSYM  (NSYM),
    .MAXLEN(MAXLEN)
  ) u_table (
    .clk_i    (clk),
    .rst_i    (rst),
    .wr_en_i  (wr_en),
    .wr_sym_i (load_sym),
    .wr_code_i(load_code),
    .wr_len_i (wr_len),
    .rd_sym_i (ptr_q),
    .rd_code_o(rd_code),
    .rd_len_o (rd_len)
  );

  assign ptr_last = mode_q ? (ptr_q == '0) : (ptr_q == SW'(NSYM - 1));
  assign ptr_next = mode_q ? (ptr_q - SW'(1)) : (ptr_q + SW'(1));
  // Left-justify the code so the shifter MSB is always the next bit out.
  assign aligned  = rd_code << (MAXLEN - 32'(rd_len));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    mode_d   = mode_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = out_mode;
          ptr_d   = out_mode ? SW'(NSYM - 1) : '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (rd_len == '0) begin
          if (ptr_last) state_d = StDone;
          else          ptr_d   = ptr_next;
        end else begin
          shreg_d  = aligned;
          bitcnt_d = rd_len;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (out_ready) begin
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q - LW'(1);
          if (bitcnt_q == LW'(1)) begin
            if (ptr_last) begin
              state_d = StDone;
            end else begin
              ptr_d   = ptr_next;
              state_d = StFetch;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      mode_q   <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      mode_q   <= mode_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StShift);
  assign out_code  = out_valid && shreg_q[MAXLEN-1];
  assign done      = done_q;

endmodule

// File: tb/tb_ht_code_serializer.sv
// Randomized self-checking bench for ht_code_serializer against a table-level reference model.
module tb_ht_code_serializer;

  localparam int NSYM   = 8;
  localparam int MAXLEN = 7;
  localparam int SW     = 3;
  localparam int LW     = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [SW-1:0]     load_sym = '0;
  logic [MAXLEN-1:0] load_code = '0;
  logic [LW-1:0]     load_len = '0;
  logic              start = 1'b0;
  logic              out_mode = 1'b0;
  logic              busy;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_code;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;
  int m_code [NSYM];
  int m_len  [NSYM];

  always #5 clk = ~clk;

  ht_code_serializer #(
    .NSYM  (NSYM),
    .MAXLEN(MAXLEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_sym  (load_sym),
    .load_code (load_code),
    .load_len  (load_len),
    .start     (start),
    .out_mode  (out_mode),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .done      (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_write(input int sym, input int code, input int len);
    if (sym < NSYM) begin
      m_code[sym] = code & ((1 << MAXLEN) - 1);
      m_len[sym]  = (len > MAXLEN) ? MAXLEN : len;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < NSYM; i++) m_len[i] = 0;
  endtask

  task automatic load(input int sym, input int code, input int len);
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_ready_idle: got %b want 1", load_ready);
    end
    load_valid = 1'b1;
    load_sym   = SW'(sym);
    load_code  = MAXLEN'(code);
    load_len   = LW'(len);
    step();
    load_valid = 1'b0;
    model_write(sym, code, len);
  endtask

  // policy 0: always ready, 1: random ready plus junk start/load while busy,
  // 2: ready held low for 3 cycles on the second bit.
  task automatic run_emission(input int mode, input int policy, input bit with_load,
                              input int lsym, input int lcode, input int llen);
    int q[$];
    int first_pos, first_valid, done_at, nvalid, acc, stall;
    bit rdy;
    first_pos = -1; first_valid = -1; done_at = -1; nvalid = 0; acc = 0; stall = 0;
    if (with_load) begin
      load_valid = 1'b1;
      load_sym   = SW'(lsym);
      load_code  = MAXLEN'(lcode);
      load_len   = LW'(llen);
      model_write(lsym, lcode, llen);
    end
    for (int j = 0; j < NSYM; j++) begin
      int i;
      i = (mode != 0) ? (NSYM - 1 - j) : j;
      if (m_len[i] != 0 && first_pos < 0) first_pos = j;
      for (int b = m_len[i] - 1; b >= 0; b--) q.push_back((m_code[i] >> b) & 1);
    end
    start    = 1'b1;
    out_mode = (mode != 0);
    out_ready = 1'b0;
    step();
    start      = 1'b0;
    load_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL busy_after_start: busy=%b load_ready=%b want 1/0", busy, load_ready);
    end
    for (int k = 1; k < 400; k++) begin
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
      if (out_valid === 1'b1) begin
        nvalid++;
        if (first_valid < 0) first_valid = k;
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL extra_bit: cycle %0d got out_code=%b want no bit", k, out_code);
        end else if (out_code !== q[0][0]) begin
          n_err++;
          $display("FAIL out_code: cycle %0d got %b want %0d", k, out_code, q[0]);
        end
      end
      if (policy == 0)      rdy = 1'b1;
      else if (policy == 1) rdy = ($urandom_range(0, 3) != 0);
      else begin
        rdy = !(acc == 1 && stall < 3);
        if (!rdy && out_valid === 1'b1) stall++;
      end
      out_ready = rdy;
      if (out_valid === 1'b1 && rdy && q.size() > 0) begin
        void'(q.pop_front());
        acc++;
      end
      if (policy == 1) begin
        start      = $urandom_range(0, 1);
        out_mode   = $urandom_range(0, 1);
        load_valid = ($urandom_range(0, 3) == 0);
        load_sym   = SW'($urandom_range(0, NSYM - 1));
        load_code  = MAXLEN'($urandom);
        load_len   = LW'($urandom_range(1, MAXLEN));
      end
      step();
      start      = 1'b0;
      load_valid = 1'b0;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (done_at != NSYM + 2 + nvalid) begin
      n_err++;
      $display("FAIL done_timing: got cycle %0d want %0d", done_at, NSYM + 2 + nvalid);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL missing_bits: got %0d bits short want 0", q.size());
    end
    if (policy == 0 && first_pos >= 0) begin
      n_cmp++;
      if (first_valid != first_pos + 2) begin
        n_err++;
        $display("FAIL first_latency: got %0d want %0d", first_valid, first_pos + 2);
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse_width: got %b want 0", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    load_valid = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    start = 1'b0;
    load_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < NSYM; i++) m_len[i] = 0;
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_code !== 1'b0) begin n_err++; $display("FAIL rst_out_code: got %b want 0", out_code); end
    if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (load_ready !== 1'b1) begin n_err++; $display("FAIL rst_load_ready: got %b want 1", load_ready); end
  endtask

  task automatic test_directed();
    do_reset();
    load(2, 3'b101, 3);
    load(5, 2'b01, 2);
    run_emission(0, 0, 1'b0, 0, 0, 0);
    run_emission(1, 0, 1'b0, 0, 0, 0);
    run_emission(0, 2, 1'b0, 0, 0, 0);
  endtask

  task automatic test_empty();
    do_reset();
    run_emission(0, 0, 1'b0, 0, 0, 0);
    run_emission(1, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_start_with_load();
    do_reset();
    run_emission(0, 0, 1'b1, 0, 1, 1);
  endtask

  task automatic test_reset_mid_shift();
    int vcnt;
    bit saw_done;
    do_reset();
    load(2, 3'b101, 3);
    load(5, 2'b01, 2);
    start = 1'b1;
    out_mode = 1'b0;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid === 1'b1) vcnt++;
      if (vcnt == 2) break;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NSYM; i++) m_len[i] = 0;
    n_cmp++;
    if (vcnt != 2 || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_shift: bits_seen=%0d busy=%b out_valid=%b done=%b want 2/0/0/0",
               vcnt, busy, out_valid, done);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (done === 1'b1) saw_done = 1'b1;
      step();
    end
    n_cmp++;
    if (saw_done) begin
      n_err++;
      $display("FAIL rst_no_done: got done pulse want none");
    end
    out_ready = 1'b0;
    run_emission(0, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < NSYM; s++) begin
        if ($urandom_range(0, 9) < 4) load(s, 0, 0);
        else load(s, $urandom, $urandom_range(1, MAXLEN));
      end
      run_emission($urandom_range(0, 1), 0, 1'b0, 0, 0, 0);
      run_emission($urandom_range(0, 1), 1, 1'b0, 0, 0, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    test_reset();
    test_directed();
    test_empty();
    test_start_with_load();
    test_reset_mid_shift();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
